// File: rtl/bvudiv_pkg.sv
// rtl/bvudiv_pkg.sv - shared types and reference arithmetic for the sequential bvudiv/bvurem divider
package bvudiv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [63:0] all_ones(input int w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    // SMT-LIB semantics: division by zero yields all-ones quotient and the dividend as remainder
    function automatic logic [63:0] ref_udiv(input logic [63:0] a, input logic [63:0] b, input int w);
        if (b == '0) return all_ones(w);
        return a / b;
    endfunction

    function automatic logic [63:0] ref_urem(input logic [63:0] a, input logic [63:0] b);
        if (b == '0) return a;
        return a % b;
    endfunction

endpackage

// File: rtl/bvudiv_step.sv
// rtl/bvudiv_step.sv - one combinational restoring-division step
module bvudiv_step #(
    parameter int W = 4
) (
    input  logic [W:0]   r,
    input  logic         q_msb,
    input  logic [W-1:0] b,
    output logic [W:0]   r_next,
    output logic         q_bit
);

    logic [W:0] t;
    logic       unused_r_msb;

    // r stays below b after every step, so its top bit is always zero
    assign unused_r_msb = r[W];
    assign t            = {r[W-1:0], q_msb};

    always_comb begin
        r_next = t;
        q_bit  = 1'b0;
        if (t >= {1'b0, b}) begin
            r_next = t - {1'b0, b};
            q_bit  = 1'b1;
        end
    end

endmodule

// File: rtl/bvudiv_seq.sv
// rtl/bvudiv_seq.sv - W-bit sequential bvudiv/bvurem, one quotient bit per cycle; BVUDIV_SKOLEM_CHECK_EN adds chk_ok
module bvudiv_seq
    import bvudiv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_q,
    output logic [W-1:0] out_r,
    output logic         out_dbz
`ifdef BVUDIV_SKOLEM_CHECK_EN
    ,
    output logic         chk_ok
`endif
);

    localparam int CNT_W = $clog2(W + 1);

    state_t           state;
    logic [W-1:0]     q_reg;
    logic [W-1:0]     b_reg;
    logic [W:0]       r_reg;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       r_next;
    logic             q_bit;
    logic [W-1:0]     q_shift;

    bvudiv_step #(.W(W)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[W-1]),
        .b      (b_reg),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    assign q_shift = {q_reg[W-2:0], q_bit};

`ifdef BVUDIV_SKOLEM_CHECK_EN
    logic [W-1:0]   a_reg;
    logic [2*W-1:0] recon;
    logic           chk_final;

    // Independent witness check on the final-step values: q*b + r == a in 2W bits and r < b
    assign recon     = {{W{1'b0}}, q_shift} * {{W{1'b0}}, b_reg} + {{W{1'b0}}, r_next[W-1:0]};
    assign chk_final = (recon == {{W{1'b0}}, a_reg}) && (r_next[W-1:0] < b_reg);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_dbz   <= 1'b0;
            q_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            cnt       <= '0;
`ifdef BVUDIV_SKOLEM_CHECK_EN
            a_reg     <= '0;
            chk_ok    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_reg    <= in_a;
                        b_reg    <= in_b;
                        r_reg    <= '0;
                        in_ready <= 1'b0;
`ifdef BVUDIV_SKOLEM_CHECK_EN
                        a_reg    <= in_a;
`endif
                        if (in_b != '0) begin
                            cnt   <= CNT_W'(W);
                            state <= CALC;
                        end else begin
                            out_q     <= W'(all_ones(W));
                            out_r     <= in_a;
                            out_dbz   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
`ifdef BVUDIV_SKOLEM_CHECK_EN
                            chk_ok    <= (W'(all_ones(W)) == {W{1'b1}});
`endif
                        end
                    end
                end
                CALC: begin
                    r_reg <= r_next;
                    q_reg <= q_shift;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        out_q     <= q_shift;
                        out_r     <= r_next[W-1:0];
                        out_dbz   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef BVUDIV_SKOLEM_CHECK_EN
                        chk_ok    <= chk_final;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bvudiv_seq.sv
// tb/tb_bvudiv_seq.sv - directed and exhaustive self-checking bench for bvudiv_seq
module tb_bvudiv_seq;
    import bvudiv_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_dbz;
    logic [3:0] in_a, in_b, out_q, out_r;
    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_dbz8;
    logic [7:0] in_a8, in_b8, out_q8, out_r8;
`ifdef BVUDIV_SKOLEM_CHECK_EN
    logic       chk_ok, chk_ok8;
`endif

    int checks = 0;
    int errors = 0;

    bvudiv_seq #(.W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz)
`ifdef BVUDIV_SKOLEM_CHECK_EN
        , .chk_ok(chk_ok)
`endif
    );

    bvudiv_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_q(out_q8), .out_r(out_r8), .out_dbz(out_dbz8)
`ifdef BVUDIV_SKOLEM_CHECK_EN
        , .chk_ok(chk_ok8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands, waits for in_ready, and returns after the accept edge (+1)
    task automatic start4(input logic [3:0] a, input logic [3:0] b);
        in_a = a; in_b = b; in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge (inclusive) until out_valid is seen
    task automatic wait_valid4(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_a = 4'd5; in_b = 4'd1; out_ready = 1'b1;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_q !== 4'd0 || out_r !== 4'd0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h dbz=%b required 1 0 0 0 0", in_ready, out_valid, out_q, out_r, out_dbz);
        end
`ifdef BVUDIV_SKOLEM_CHECK_EN
        checks++;
        if (chk_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_chk: chk_ok=%b required 0", chk_ok);
        end
`endif
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignore_valid: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        start4(4'd13, 4'd3);
        wait_valid4(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 5", lat);
        end
        checks++;
        if (out_q !== 4'd4 || out_r !== 4'd1 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dbz=%b required 4 1 0", out_q, out_r, out_dbz);
        end
`ifdef BVUDIV_SKOLEM_CHECK_EN
        checks++;
        if (chk_ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_chk: chk_ok=%b required 1", chk_ok);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return_idle: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_dbz;
        int lat;
        out_ready = 1'b1;
        start4(4'd9, 4'd0);
        wait_valid4(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d required 1", lat);
        end
        checks++;
        if (out_q !== 4'hF || out_r !== 4'd9 || out_dbz !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%0d dbz=%b required F 9 1", out_q, out_r, out_dbz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        start4(4'd15, 4'd1);
        wait_valid4(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL bp_latency: got %0d required 5", lat);
        end
        in_a = 4'd3; in_b = 4'd2; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 4'd15 || out_r !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b q=%0d r=%0d required 1 0 15 0", i, out_valid, in_ready, out_q, out_r);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_complete: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic saw;
        out_ready = 1'b1;
        start4(4'd7, 4'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_q !== 4'd0 || out_r !== 4'd0 || out_dbz !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: rdy=%b vld=%b q=%h r=%h dbz=%b required 1 0 0 0 0", in_ready, out_valid, out_q, out_r, out_dbz);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            saw = saw | out_valid;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_result: saw out_valid=%b required 0", saw);
        end
        start4(4'd7, 4'd2);
        wait_valid4(lat);
        checks++;
        if (lat !== 5 || out_q !== 4'd3 || out_r !== 4'd1) begin
            errors++;
            $display("FAIL midreset_next_op: lat=%0d q=%0d r=%0d required 5 3 1", lat, out_q, out_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        int nerr;
        logic [63:0] eq, er;
        nerr = 0;
        out_ready = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = ref_udiv(64'(a), 64'(b), 4);
                er = ref_urem(64'(a), 64'(b));
                start4(4'(a), 4'(b));
                wait_valid4(lat);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                checks++;
                if (out_valid !== 1'b1 || out_q !== eq[3:0] || out_r !== er[3:0] || out_dbz !== (b == 0)
                    || lat !== ((b == 0) ? 1 : 5)) begin
                    errors++;
                    nerr++;
                    if (nerr < 10)
                        $display("FAIL exh a=%0d b=%0d: vld=%b q=%0d r=%0d dbz=%b lat=%0d required 1 %0d %0d %0d %0d",
                                 a, b, out_valid, out_q, out_r, out_dbz, lat, eq[3:0], er[3:0], (b == 0), (b == 0) ? 1 : 5);
                end
`ifdef BVUDIV_SKOLEM_CHECK_EN
                checks++;
                if (chk_ok !== 1'b1) begin
                    errors++;
                    $display("FAIL exh_chk a=%0d b=%0d: chk_ok=%b required 1", a, b, chk_ok);
                end
`endif
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_w8;
        int lat;
        in_a8 = 8'd200; in_b8 = 8'd7; in_valid8 = 1'b1;
        for (int i = 0; i < 40 && !in_ready8; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL w8_latency: got %0d required 9", lat);
        end
        checks++;
        if (out_q8 !== 8'd28 || out_r8 !== 8'd4 || out_dbz8 !== 1'b0) begin
            errors++;
            $display("FAIL w8_result: q=%0d r=%0d dbz=%b required 28 4 0", out_q8, out_r8, out_dbz8);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_dbz;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_w8;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
